scanner_ctrl_p: RTL

Parametrised successor to the single-channel fake-data scanner. It fills a DEPTH-word sample buffer at a divided scan rate and emits threshold commands (80 %, 90 %, 100 %) on a two-wire serial link (clk_out/data_out). When the peer is ready, it drains the full buffer as a framed data transfer. It sits between the local sensor stub and the link output driver; commands and data share one serialiser with a one-deep pending-command slot.

---
 rtl/scanner_ctrl_p.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/scanner_ctrl_p.sv
// Scan-rate sample buffer with 80/90/100 % threshold commands and framed buffer drains,
// all sent over one bit-serial link (clk_out/data_out) with a one-deep pending command slot.
module scanner_ctrl_p #(
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CMD_W    = 8,
  parameter int unsigned SCAN_DIV = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 ctrl_in,
  input  logic                       ready_for_transfer_in,
  output logic                       clk_out,
  output logic                       data_out,
  output logic [1:0]                 ps,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       tx_busy
);

  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned SH_W   = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int unsigned BIT_W  = $clog2(SH_W + 1);
  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);

  localparam logic [FILL_W-1:0] FullFill = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] Th80     = FILL_W'((DEPTH * 8) / 10);
  localparam logic [FILL_W-1:0] Th90     = FILL_W'((DEPTH * 9) / 10);
  localparam logic [PTR_W-1:0]  LastPtr  = PTR_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]  LastDiv  = DIV_W'(SCAN_DIV - 1);

  localparam logic [1:0] CtrlStart = 2'b01;
  localparam logic [1:0] CtrlHalf  = 2'b10;
  localparam logic [1:0] CtrlStop  = 2'b11;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StActive   = 2'b01,
    StStandby  = 2'b10,
    StTransfer = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    XferHdr,
    XferCnt,
    XferData,
    XferDone
  } xfer_t;

  state_t             stateQ, stateD;
  xfer_t              xferQ, xferD;
  logic [DIV_W-1:0]   divQ;
  logic [FILL_W-1:0]  fillQ, fillD;
  logic [FILL_W-1:0]  sentQ, sentD;
  logic [PTR_W-1:0]   wrPtrQ, wrPtrD;
  logic [PTR_W-1:0]   rdPtrQ, rdPtrD;
  logic [DATA_W-1:0]  sampleQ, sampleD;
  logic               stopSeenQ, stopSeenD;
  logic               pendValidQ, pendValidD;
  logic [CMD_W-1:0]   pendCmdQ, pendCmdD;

  logic               txBusyQ, txBusyD;
  logic               txPhaseQ, txPhaseD;
  logic               txIsDataQ, txIsDataD;
  logic [SH_W-1:0]    txShiftQ, txShiftD;
  logic [BIT_W-1:0]   txBitsQ, txBitsD;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               tick;
  logic               memWe;
  logic               evValid;
  logic [CMD_W-1:0]   evCmd;
  logic               loadEn;
  logic               loadIsData;
  logic [SH_W-1:0]    loadData;
  logic [FILL_W-1:0]  newFill;
  logic [BIT_W-1:0]   lastBit;

  assign tick    = (divQ == LastDiv);
  assign newFill = fillQ + 1'b1;

  // Control FSM, buffer bookkeeping and serialiser arbitration.
  always_comb begin
    stateD     = stateQ;
    xferD      = xferQ;
    fillD      = fillQ;
    sentD      = sentQ;
    wrPtrD     = wrPtrQ;
    rdPtrD     = rdPtrQ;
    sampleD    = sampleQ;
    stopSeenD  = stopSeenQ;
    pendValidD = pendValidQ;
    pendCmdD   = pendCmdQ;
    memWe      = 1'b0;
    evValid    = 1'b0;
    evCmd      = '0;
    loadEn     = 1'b0;
    loadIsData = 1'b0;
    loadData   = '0;

    unique case (stateQ)
      StIdle: begin
        if (ctrl_in == CtrlStart) stateD = StActive;
      end
      StActive: begin
        if (tick && (fillQ < FullFill)) begin
          memWe   = 1'b1;
          fillD   = newFill;
          wrPtrD  = (wrPtrQ == LastPtr) ? '0 : wrPtrQ + 1'b1;
          sampleD = sampleQ + 1'b1;
          if (newFill == Th80) begin
            evValid = 1'b1;
            evCmd   = CMD_W'(2);
          end else if (newFill == Th90) begin
            evValid = 1'b1;
            evCmd   = CMD_W'(3);
          end else if (newFill == FullFill) begin
            evValid = 1'b1;
            evCmd   = CMD_W'(4);
            stateD  = ready_for_transfer_in ? StTransfer : StStandby;
          end
        end
        // Stop wins over the full-buffer transition; the sample above is still kept.
        if (ctrl_in == CtrlStop) stateD = StIdle;
      end
      StStandby: begin
        if (ctrl_in == CtrlStop) begin
          stateD = StIdle;
        end else if (ready_for_transfer_in || (ctrl_in == CtrlHalf)) begin
          stateD = StTransfer;
        end
      end
      StTransfer: begin
        if (ctrl_in == CtrlStop) stopSeenD = 1'b1;
      end
    endcase

    // The serialiser takes a new frame only in the cycle after it drops busy, which gives
    // exactly one idle cycle between back-to-back frames.
    if (!txBusyQ) begin
      if (pendValidQ) begin
        loadEn     = 1'b1;
        loadData   = SH_W'(pendCmdQ);
        pendValidD = evValid;
        pendCmdD   = evCmd;
      end else if (evValid) begin
        loadEn   = 1'b1;
        loadData = SH_W'(evCmd);
      end else if (stateQ == StTransfer) begin
        unique case (xferQ)
          XferHdr: begin
            loadEn   = 1'b1;
            loadData = SH_W'(7);
            xferD    = XferCnt;
          end
          XferCnt: begin
            loadEn   = 1'b1;
            loadData = SH_W'(fillQ);
            sentD    = '0;
            xferD    = (fillQ == '0) ? XferDone : XferData;
          end
          XferData: begin
            loadEn     = 1'b1;
            loadIsData = 1'b1;
            loadData   = SH_W'(mem[rdPtrQ]);
            rdPtrD     = (rdPtrQ == LastPtr) ? '0 : rdPtrQ + 1'b1;
            sentD      = sentQ + 1'b1;
            if (sentD == fillQ) xferD = XferDone;
          end
          XferDone: begin
            fillD     = '0;
            wrPtrD    = '0;
            rdPtrD    = '0;
            stopSeenD = 1'b0;
            xferD     = XferHdr;
            stateD    = (stopSeenQ || (ctrl_in == CtrlStop)) ? StIdle : StActive;
          end
        endcase
      end
    end else if (evValid) begin
      // Busy: newest command replaces whatever is waiting.
      pendValidD = 1'b1;
      pendCmdD   = evCmd;
    end
  end

  assign lastBit = txIsDataQ ? BIT_W'(DATA_W - 1) : BIT_W'(CMD_W - 1);

  // Two cycles per bit: phase 0 presents the bit, phase 1 raises the link clock.
  always_comb begin
    txBusyD   = txBusyQ;
    txPhaseD  = txPhaseQ;
    txIsDataD = txIsDataQ;
    txShiftD  = txShiftQ;
    txBitsD   = txBitsQ;
    if (loadEn) begin
      txBusyD   = 1'b1;
      txPhaseD  = 1'b0;
      txIsDataD = loadIsData;
      txShiftD  = loadData;
      txBitsD   = '0;
    end else if (txBusyQ) begin
      if (!txPhaseQ) begin
        txPhaseD = 1'b1;
      end else begin
        txPhaseD = 1'b0;
        txShiftD = txShiftQ >> 1;
        txBitsD  = txBitsQ + 1'b1;
        if (txBitsQ == lastBit) txBusyD = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      xferQ      <= XferHdr;
      divQ       <= '0;
      fillQ      <= '0;
      sentQ      <= '0;
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      sampleQ    <= '0;
      stopSeenQ  <= 1'b0;
      pendValidQ <= 1'b0;
      pendCmdQ   <= '0;
      txBusyQ    <= 1'b0;
      txPhaseQ   <= 1'b0;
      txIsDataQ  <= 1'b0;
      txShiftQ   <= '0;
      txBitsQ    <= '0;
    end else begin
      stateQ     <= stateD;
      xferQ      <= xferD;
      divQ       <= tick ? '0 : divQ + 1'b1;
      fillQ      <= fillD;
      sentQ      <= sentD;
      wrPtrQ     <= wrPtrD;
      rdPtrQ     <= rdPtrD;
      sampleQ    <= sampleD;
      stopSeenQ  <= stopSeenD;
      pendValidQ <= pendValidD;
      pendCmdQ   <= pendCmdD;
      txBusyQ    <= txBusyD;
      txPhaseQ   <= txPhaseD;
      txIsDataQ  <= txIsDataD;
      txShiftQ   <= txShiftD;
      txBitsQ    <= txBitsD;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[wrPtrQ] <= sampleQ;
  end

  assign clk_out  = txBusyQ & txPhaseQ;
  assign data_out = txBusyQ & txShiftQ[0];
  assign tx_busy  = txBusyQ;
  assign ps       = stateQ;
  assign fill     = fillQ;

endmodule
